prog_mem: RTL and testbench

Parametrised, writable program memory for the SAP datapath, successor to the fixed 16x8 program ROM. It self-initialises from a built-in demo image after reset, serves registered reads to the bus under `CE_`, and accepts a complete replacement program through a byte-stream loader handshake. No CPU changes are needed: the bus-facing side keeps the `address` / `CE_` / tri-state output contract.

---
 rtl/prog_mem_if.sv | 29 ++
 rtl/prog_mem.sv | 129 ++++++++++++
 tb/tb_prog_mem.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
`default_nettype none
// ============================================================================
// prog_mem_if : bus-read and program-loader signal group for prog_mem
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              CE_;
  logic              Load_;
  logic [DATA_W-1:0] LD_Data;
  logic              LD_Valid;
  logic              LD_Ready;
  logic              LD_Done;
  logic              Mem_Rdy;

  modport master (
    output address, CE_, Load_, LD_Data, LD_Valid,
    input  LD_Ready, LD_Done, Mem_Rdy
  );

  modport slave (
    input  address, CE_, Load_, LD_Data, LD_Valid,
    output LD_Ready, LD_Done, Mem_Rdy
  );
endinterface
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// prog_mem : writable SAP program memory; self-initialises after reset, then
//            serves registered reads and accepts a streamed replacement image.
//            Macro PROG_MEM_DEFAULT_IMAGE_EN: INIT writes the demo image,
//            otherwise INIT clears every word.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  wire logic              CLK,
  input  wire logic              CLR_,
  prog_mem_if.slave              bus,
  output wire       [DATA_W-1:0] Mem_Out
);

  localparam int         c_depth  = 1 << ADDR_W;
  localparam logic [1:0] c_s_init = 2'd0;
  localparam logic [1:0] c_s_run  = 2'd1;
  localparam logic [1:0] c_s_load = 2'd2;
  localparam logic [1:0] c_s_done = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rd;
  logic [DATA_W-1:0] r_mem [c_depth];

  logic              w_cnt_last;
  logic              w_accept;
  logic              w_ld_ready;
  logic              w_ld_done;
  logic              w_mem_rdy;
  logic              w_in_init;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_init_data;

`ifdef PROG_MEM_DEFAULT_IMAGE_EN
  function automatic logic [DATA_W-1:0] img_word(input logic [ADDR_W-1:0] idx);
    int unsigned i;
    logic [7:0]  b;
    i = int'(idx);
    case (i)
      0:       b = 8'h09;
      1:       b = 8'h1A;
      2:       b = 8'h1B;
      3:       b = 8'h2C;
      4:       b = 8'h3D;
      5:       b = 8'h4E;
      6:       b = 8'h50;
      7:       b = 8'hE0;
      8:       b = 8'hF0;
      9:       b = 8'h10;
      10:      b = 8'h14;
      11:      b = 8'h18;
      12:      b = 8'h20;
      13:      b = 8'hFF;
      14:      b = 8'h07;
      15:      b = 8'hF7;
      default: b = 8'h00;
    endcase
    return DATA_W'(b);
  endfunction

  assign w_init_data = img_word(r_cnt);
`else
  assign w_init_data = '0;
`endif

  assign w_cnt_last = (r_cnt == '1);
  assign w_in_init  = (r_state == c_s_init);
  assign w_accept   = w_ld_ready & bus.LD_Valid;

  always_ff @(posedge CLK) begin
    if (!CLR_) r_state <= c_s_init;
    else       r_state <= w_state_nxt;
  end

  // An abort (Load_ high in LOAD) wins over completing the image.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_init: if (w_cnt_last) w_state_nxt = c_s_run;
      c_s_run:  if (!bus.Load_) w_state_nxt = c_s_load;
      c_s_load: begin
        if (bus.Load_)                  w_state_nxt = c_s_run;
        else if (w_accept && w_cnt_last) w_state_nxt = c_s_done;
      end
      c_s_done: if (bus.Load_) w_state_nxt = c_s_run;
      default:  w_state_nxt = c_s_init;
    endcase
  end

  always_comb begin
    w_ld_ready = (r_state == c_s_load);
    w_ld_done  = (r_state == c_s_done);
    w_mem_rdy  = (r_state == c_s_run);
  end

  assign bus.LD_Ready = w_ld_ready;
  assign bus.LD_Done  = w_ld_done;
  assign bus.Mem_Rdy  = w_mem_rdy;

  // INIT and LOAD share one address counter; it wraps to 0 after INIT.
  always_ff @(posedge CLK) begin
    if (!CLR_)                        r_cnt <= '0;
    else if (w_in_init || w_accept)   r_cnt <= r_cnt + ADDR_W'(1);
    else if (w_mem_rdy && !bus.Load_) r_cnt <= '0;
  end

  always_ff @(posedge CLK) begin
    if (!CLR_)                       r_rd <= '0;
    else if (w_mem_rdy && bus.Load_) r_rd <= r_mem[bus.address];
  end

  assign w_we    = CLR_ & (w_in_init | w_accept);
  assign w_wdata = w_in_init ? w_init_data : bus.LD_Data;

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[r_cnt] <= w_wdata;
  end

  assign Mem_Out = (bus.CE_ | ~w_mem_rdy) ? {DATA_W{1'bz}} : r_rd;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// tb_prog_mem : directed self-checking bench for prog_mem (default 16x8).
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       clr_n;
  wire  [7:0] mem_out;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] img_exp [16];
  logic [7:0] zz;

  prog_mem_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  prog_mem #(.DATA_W(8), .ADDR_W(4)) dut (
    .CLK     (clk),
    .CLR_    (clr_n),
    .bus     (bus.slave),
    .Mem_Out (mem_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.Mem_Rdy !== 1'b0 || bus.LD_Ready !== 1'b0 || bus.LD_Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b ready=%b done=%b expected 0 0 0",
               bus.Mem_Rdy, bus.LD_Ready, bus.LD_Done);
    end
    checks++;
    if (mem_out !== zz) begin
      errors++;
      $display("FAIL reset_out_z: got %h expected %h", mem_out, zz);
    end
    clr_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (bus.Mem_Rdy !== (k == 16)) begin
        errors++;
        $display("FAIL init_rdy edge %0d: got %b expected %b", k, bus.Mem_Rdy, (k == 16));
      end
    end
    checks++;
    if (mem_out !== 8'h00) begin
      errors++;
      $display("FAIL first_read_reset_val: got %h expected 00", mem_out);
    end
  endtask

  task automatic test_readback();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 4'h0 : (i == 1) ? 4'h3 : (i == 2) ? 4'hD : 4'hF;
      bus.address = a;
      tick();
      checks++;
      if (mem_out !== img_exp[a]) begin
        errors++;
        $display("FAIL readback addr %h: got %h expected %h", a, mem_out, img_exp[a]);
      end
    end
    bus.CE_ = 1'b1;
    #1;
    checks++;
    if (mem_out !== zz) begin
      errors++;
      $display("FAIL ce_high_z: got %h expected %h", mem_out, zz);
    end
    bus.CE_ = 1'b0;
    #1;
    checks++;
    if (mem_out !== img_exp[15]) begin
      errors++;
      $display("FAIL ce_low_redrive: got %h expected %h", mem_out, img_exp[15]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    bus.Load_ = 1'b0;
    tick();
    checks++;
    if (bus.LD_Ready !== 1'b1 || bus.Mem_Rdy !== 1'b0 || mem_out !== zz) begin
      errors++;
      $display("FAIL abort_enter_load: got ready=%b rdy=%b out=%h expected 1 0 z",
               bus.LD_Ready, bus.Mem_Rdy, mem_out);
    end
    for (int i = 0; i < 3; i++) begin
      bus.LD_Data  = 8'h11 * 8'(i + 1);
      bus.LD_Valid = 1'b1;
      tick();
    end
    bus.LD_Valid = 1'b0;
    bus.Load_    = 1'b1;
    tick();
    checks++;
    if (bus.Mem_Rdy !== 1'b1 || bus.LD_Done !== 1'b0 || bus.LD_Ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got rdy=%b done=%b ready=%b expected 1 0 0",
               bus.Mem_Rdy, bus.LD_Done, bus.LD_Ready);
    end
    // Valid data in RUN must not write anything.
    bus.LD_Valid = 1'b1;
    bus.LD_Data  = 8'h77;
    for (int a = 0; a < 4; a++) begin
      exp = (a == 0) ? 8'h11 : (a == 1) ? 8'h22 : (a == 2) ? 8'h33 : img_exp[3];
      bus.address = 4'(a);
      tick();
      checks++;
      if (mem_out !== exp) begin
        errors++;
        $display("FAIL abort_read addr %0d: got %h expected %h", a, mem_out, exp);
      end
    end
    bus.LD_Valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bus.Load_ = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.LD_Data  = 8'h50 + 8'(i);
      bus.LD_Valid = 1'b1;
      tick();
    end
    clr_n = 1'b0;
    tick();
    checks++;
    if (bus.LD_Ready !== 1'b0 || bus.Mem_Rdy !== 1'b0 || bus.LD_Done !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset_flags: got ready=%b rdy=%b done=%b expected 0 0 0",
               bus.LD_Ready, bus.Mem_Rdy, bus.LD_Done);
    end
    clr_n        = 1'b1;
    bus.Load_    = 1'b1;
    bus.LD_Valid = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    checks++;
    if (bus.Mem_Rdy !== 1'b1) begin
      errors++;
      $display("FAIL midload_reinit_rdy: got %b expected 1", bus.Mem_Rdy);
    end
    bus.address = 4'h0;
    tick();
    checks++;
    if (mem_out !== img_exp[0]) begin
      errors++;
      $display("FAIL midload_addr0: got %h expected %h", mem_out, img_exp[0]);
    end
    bus.address = 4'h4;
    tick();
    checks++;
    if (mem_out !== img_exp[4]) begin
      errors++;
      $display("FAIL midload_addr4: got %h expected %h", mem_out, img_exp[4]);
    end
  endtask

  task automatic test_full_load();
    bus.Load_ = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.LD_Data  = 8'hA0 + 8'(i);
      bus.LD_Valid = 1'b1;
      checks++;
      if (bus.LD_Ready !== 1'b1 || bus.LD_Done !== 1'b0) begin
        errors++;
        $display("FAIL full_ready word %0d: got ready=%b done=%b expected 1 0",
                 i, bus.LD_Ready, bus.LD_Done);
      end
      tick();
    end
    bus.LD_Valid = 1'b0;
    checks++;
    if (bus.LD_Done !== 1'b1 || bus.LD_Ready !== 1'b0 || bus.Mem_Rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got done=%b ready=%b rdy=%b expected 1 0 0",
               bus.LD_Done, bus.LD_Ready, bus.Mem_Rdy);
    end
    tick();
    checks++;
    if (bus.LD_Done !== 1'b1) begin
      errors++;
      $display("FAIL full_done_hold: got %b expected 1", bus.LD_Done);
    end
    bus.Load_ = 1'b1;
    tick();
    checks++;
    if (bus.Mem_Rdy !== 1'b1 || bus.LD_Done !== 1'b0) begin
      errors++;
      $display("FAIL full_back_to_run: got rdy=%b done=%b expected 1 0",
               bus.Mem_Rdy, bus.LD_Done);
    end
    bus.address = 4'h5;
    tick();
    checks++;
    if (mem_out !== 8'hA5) begin
      errors++;
      $display("FAIL full_addr5: got %h expected a5", mem_out);
    end
    bus.address = 4'hF;
    tick();
    checks++;
    if (mem_out !== 8'hAF) begin
      errors++;
      $display("FAIL full_addrF: got %h expected af", mem_out);
    end
  endtask

  task automatic test_gapped_load();
    bus.Load_ = 1'b0;
    tick();
    for (int c = 0; c < 32; c++) begin
      bus.LD_Valid = (c % 2 == 0);
      bus.LD_Data  = (c % 2 == 0) ? 8'h40 + 8'(c / 2) : 8'hEE;
      tick();
      if (c == 29) begin
        checks++;
        if (bus.LD_Done !== 1'b0 || bus.LD_Ready !== 1'b1) begin
          errors++;
          $display("FAIL gapped_early: got done=%b ready=%b expected 0 1",
                   bus.LD_Done, bus.LD_Ready);
        end
      end
    end
    bus.LD_Valid = 1'b0;
    checks++;
    if (bus.LD_Done !== 1'b1) begin
      errors++;
      $display("FAIL gapped_done: got %b expected 1", bus.LD_Done);
    end
    bus.Load_ = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.address = (i == 0) ? 4'h0 : (i == 1) ? 4'h7 : 4'hF;
      tick();
      checks++;
      if (mem_out !== 8'h40 + 8'(bus.address)) begin
        errors++;
        $display("FAIL gapped_read addr %h: got %h expected %h",
                 bus.address, mem_out, 8'h40 + 8'(bus.address));
      end
    end
  endtask

  task automatic test_last_word_abort();
    bus.Load_ = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.LD_Data  = 8'hC0 + 8'(i);
      bus.LD_Valid = 1'b1;
      if (i == 15) bus.Load_ = 1'b1;
      tick();
    end
    bus.LD_Valid = 1'b0;
    checks++;
    if (bus.Mem_Rdy !== 1'b1 || bus.LD_Done !== 1'b0) begin
      errors++;
      $display("FAIL lastword_abort_flags: got rdy=%b done=%b expected 1 0",
               bus.Mem_Rdy, bus.LD_Done);
    end
    bus.address = 4'hF;
    tick();
    checks++;
    if (mem_out !== 8'hCF) begin
      errors++;
      $display("FAIL lastword_addrF: got %h expected cf", mem_out);
    end
    bus.address = 4'h0;
    tick();
    checks++;
    if (mem_out !== 8'hC0) begin
      errors++;
      $display("FAIL lastword_addr0: got %h expected c0", mem_out);
    end
  endtask

  initial begin
`ifdef PROG_MEM_DEFAULT_IMAGE_EN
    img_exp = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'h3D, 8'h4E, 8'h50, 8'hE0,
                8'hF0, 8'h10, 8'h14, 8'h18, 8'h20, 8'hFF, 8'h07, 8'hF7};
`else
    foreach (img_exp[i]) img_exp[i] = 8'h00;
`endif
    zz           = 8'bzzzz_zzzz;
    clr_n        = 1'b0;
    bus.address  = 4'h0;
    bus.CE_      = 1'b0;
    bus.Load_    = 1'b1;
    bus.LD_Data  = 8'h00;
    bus.LD_Valid = 1'b0;

    test_reset();
    test_readback();
    test_abort();
    test_reset_mid_load();
    test_full_load();
    test_gapped_load();
    test_last_word_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
